// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared RC4 pipeline types and constants. Holds the message
//                checker state encoding and the legal-character bounds.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

  // Message checker states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } msg_check_state_t;

  // Legal plaintext alphabet: lowercase letters plus space
  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int MSG_LEN_DEFAULT = 32;

endpackage
`default_nettype wire

// File: rtl/char_is_legal.sv
`default_nettype none
// ============================================================================
//  Module      : char_is_legal
//  Description : Combinational classifier. Flags a byte as legal when it is
//                a lowercase ASCII letter ('a'..'z') or a space.
//  Ports       : i_char  [7:0] in  - byte under test
//                o_legal       out - 1 when i_char is legal
//  Revision    : 1.0 - initial release
// ============================================================================
module char_is_legal
  import rc4_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_legal
);

  assign o_legal = ((i_char >= CHAR_LO) && (i_char <= CHAR_HI)) ||
                   (i_char == CHAR_SPACE);

endmodule
`default_nettype wire

// File: rtl/msg_check_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : msg_check_fsm
//  Description : Walks the decrypted-message RAM one byte at a time and
//                reports whether every byte is a lowercase letter or space.
//                Stops at the first illegal byte and records its address and
//                value. All outputs are registered.
//  Ports       : clk              in  - system clock
//                reset            in  - asynchronous reset, active low
//                start            in  - level; starts a check from IDLE
//                q        [7:0]   in  - message RAM read data
//                address  [AW-1:0]out - message RAM read address
//                rden             out - message RAM read enable
//                done             out - high while results are held
//                pass             out - 1 when all bytes legal (with done)
//                bad_addr [AW-1:0]out - address of first illegal byte
//                bad_char [7:0]   out - value of first illegal byte
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_check_fsm
  import rc4_pkg::*;
#(
  parameter int MSG_LEN    = MSG_LEN_DEFAULT,
  parameter int ADDR_W     = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        q,
  output logic [ADDR_W-1:0] address,
  output logic              rden,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] bad_addr,
  output logic [7:0]        bad_char
);

  // One extra bit so the index can never wrap back to zero, and the
  // last-byte compare is done at full width.
  localparam logic [ADDR_W:0] c_last_idx = (ADDR_W+1)'(MSG_LEN - 1);

  msg_check_state_t  r_state;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   w_idx_next;
  logic              w_q_legal;

  assign w_idx_next = r_idx + 1'b1;

  char_is_legal u_char_is_legal (
    .i_char  (q),
    .o_legal (w_q_legal)
  );

  // Outputs are registered on state entry, so address/rden are already
  // valid during the ISSUE cycle itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      address  <= '0;
      rden     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      bad_addr <= '0;
      bad_char <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx    <= '0;
            pass     <= 1'b0;
            bad_addr <= '0;
            bad_char <= '0;
            address  <= '0;
            rden     <= 1'b1;
            r_state  <= ISSUE;
          end
        end

        ISSUE: begin
          if (RD_LATENCY == 1) begin
            rden    <= 1'b0;
            r_state <= CHECK;
          end else begin
            // Keep address and rden asserted through the extra RAM stage
            r_state <= WAIT;
          end
        end

        WAIT: begin
          rden    <= 1'b0;
          r_state <= CHECK;
        end

        CHECK: begin
          if (!w_q_legal) begin
            bad_addr <= r_idx[ADDR_W-1:0];
            bad_char <= q;
            pass     <= 1'b0;
            done     <= 1'b1;
            r_state  <= DONE;
          end else if (r_idx == c_last_idx) begin
            pass    <= 1'b1;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx   <= w_idx_next;
            address <= w_idx_next[ADDR_W-1:0];
            rden    <= 1'b1;
            r_state <= ISSUE;
          end
        end

        DONE: begin
          // Wait for start to drop so a held level cannot retrigger
          if (!start) begin
            done    <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          rden    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
